// File: rtl/gtech_xnor_parity_frame_checker.sv
// XNOR parity frame checker: accumulates parity over a multi-beat frame and emits one result per
// frame through a registered valid/ready output. `GTECH_PARITY_ERRCNT_EN adds a saturating ERR_CNT.
module gtech_xnor_parity_frame_checker #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned LEN_W  = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [DATA_W-1:0] IN_DATA,
  input  logic              IN_LAST,
  input  logic              IN_PAR,
  output logic              RES_VALID,
  input  logic              RES_READY,
  output logic              RES_PAR,
  output logic              RES_ERR,
  output logic [LEN_W-1:0]  RES_LEN,
  output logic              RES_SAT
`ifdef GTECH_PARITY_ERRCNT_EN
  ,
  output logic [15:0]       ERR_CNT
`endif
);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StAcc  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic             acc_q, acc_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             res_valid_q, res_valid_d;
  logic             res_par_q, res_par_d;
  logic             res_err_q, res_err_d;
  logic [LEN_W-1:0] res_len_q, res_len_d;
  logic             res_sat_q, res_sat_d;

  logic             in_fire;
  logic             load;
  logic             beat_par;
  logic             frame_par;
  logic [LEN_W:0]   cnt_inc;
  logic [LEN_W-1:0] len_next;
  logic             len_sat;

  assign IN_READY  = ~res_valid_q | RES_READY;
  assign in_fire   = IN_VALID & IN_READY;
  assign load      = in_fire & IN_LAST;
  assign beat_par  = ^IN_DATA;
  assign frame_par = ~(acc_q ^ beat_par);

  // Carry out of cnt+1 means the frame length no longer fits in LEN_W bits.
  assign cnt_inc  = {1'b0, cnt_q} + {{LEN_W{1'b0}}, 1'b1};
  assign len_sat  = cnt_inc[LEN_W];
  assign len_next = len_sat ? {LEN_W{1'b1}} : cnt_inc[LEN_W-1:0];

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    if (in_fire) begin
      if (IN_LAST) begin
        state_d = StIdle;
        acc_d   = 1'b0;
        cnt_d   = '0;
      end else begin
        case (state_q)
          StIdle: begin
            state_d = StAcc;
            acc_d   = beat_par;
            cnt_d   = {{(LEN_W-1){1'b0}}, 1'b1};
          end
          default: begin
            acc_d = acc_q ^ beat_par;
            cnt_d = len_next;
          end
        endcase
      end
    end
  end

  always_comb begin
    res_valid_d = res_valid_q;
    res_par_d   = res_par_q;
    res_err_d   = res_err_q;
    res_len_d   = res_len_q;
    res_sat_d   = res_sat_q;
    if (load) begin
      res_valid_d = 1'b1;
      res_par_d   = frame_par;
      res_err_d   = frame_par ^ IN_PAR;
      res_len_d   = len_next;
      res_sat_d   = len_sat;
    end else if (RES_READY) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= StIdle;
      acc_q       <= 1'b0;
      cnt_q       <= '0;
      res_valid_q <= 1'b0;
      res_par_q   <= 1'b0;
      res_err_q   <= 1'b0;
      res_len_q   <= '0;
      res_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      res_valid_q <= res_valid_d;
      res_par_q   <= res_par_d;
      res_err_q   <= res_err_d;
      res_len_q   <= res_len_d;
      res_sat_q   <= res_sat_d;
    end
  end

  assign RES_VALID = res_valid_q;
  assign RES_PAR   = res_par_q;
  assign RES_ERR   = res_err_q;
  assign RES_LEN   = res_len_q;
  assign RES_SAT   = res_sat_q;

`ifdef GTECH_PARITY_ERRCNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (load && (frame_par ^ IN_PAR) && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      err_cnt_q <= 16'd0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign ERR_CNT = err_cnt_q;
`endif

endmodule

// File: tb/tb_gtech_xnor_parity_frame_checker.sv
// Directed bench for gtech_xnor_parity_frame_checker: a default instance plus a LEN_W=2 instance
// for length saturation.
module tb_gtech_xnor_parity_frame_checker;

  logic       clk;
  logic       rst;
  logic       in_valid, in_last, in_par, res_ready;
  logic [7:0] in_data;
  logic       in_ready, res_valid, res_par, res_err, res_sat;
  logic [7:0] res_len;

  logic       in_valid2, in_last2, in_par2, res_ready2;
  logic [7:0] in_data2;
  logic       in_ready2, res_valid2, res_par2, res_err2, res_sat2;
  logic [1:0] res_len2;

`ifdef GTECH_PARITY_ERRCNT_EN
  logic [15:0] err_cnt, err_cnt2;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  gtech_xnor_parity_frame_checker #(.DATA_W(8), .LEN_W(8)) dut (
    .CLK       (clk),
    .RST       (rst),
    .IN_VALID  (in_valid),
    .IN_READY  (in_ready),
    .IN_DATA   (in_data),
    .IN_LAST   (in_last),
    .IN_PAR    (in_par),
    .RES_VALID (res_valid),
    .RES_READY (res_ready),
    .RES_PAR   (res_par),
    .RES_ERR   (res_err),
    .RES_LEN   (res_len),
    .RES_SAT   (res_sat)
`ifdef GTECH_PARITY_ERRCNT_EN
    ,
    .ERR_CNT   (err_cnt)
`endif
  );

  gtech_xnor_parity_frame_checker #(.DATA_W(8), .LEN_W(2)) dut2 (
    .CLK       (clk),
    .RST       (rst),
    .IN_VALID  (in_valid2),
    .IN_READY  (in_ready2),
    .IN_DATA   (in_data2),
    .IN_LAST   (in_last2),
    .IN_PAR    (in_par2),
    .RES_VALID (res_valid2),
    .RES_READY (res_ready2),
    .RES_PAR   (res_par2),
    .RES_ERR   (res_err2),
    .RES_LEN   (res_len2),
    .RES_SAT   (res_sat2)
`ifdef GTECH_PARITY_ERRCNT_EN
    ,
    .ERR_CNT   (err_cnt2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one beat for one clock edge; returns 1 time unit after that edge.
  task automatic beat(input logic [7:0] d, input logic last, input logic par);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    in_par   = par;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic beat2(input logic [7:0] d, input logic last, input logic par);
    in_valid2 = 1'b1;
    in_data2  = d;
    in_last2  = last;
    in_par2   = par;
    @(posedge clk);
    #1;
    in_valid2 = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 0; in_data = 0; in_last = 0; in_par = 0; res_ready = 1;
    in_valid2 = 0; in_data2 = 0; in_last2 = 0; in_par2 = 0; res_ready2 = 1;
    #3;
    n_cmp++;
    if ({res_valid, res_par, res_err, res_len, res_sat} !== 12'h000) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h want 000",
               {res_valid, res_par, res_err, res_len, res_sat});
    end
    #4 rst = 1'b0;
    idle_cycle();
    n_cmp++;
    if (in_ready !== 1'b1 || res_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_ready: got in_ready=%b res_valid=%b want 1 0", in_ready, res_valid);
    end
  endtask

  task automatic test_two_beat();
    res_ready = 1'b1;
    beat(8'h01, 1'b0, 1'b0);
    n_cmp++;
    if (res_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL two_beat_mid: got res_valid=%b want 0", res_valid);
    end
    beat(8'h02, 1'b1, 1'b1);
    n_cmp++;
    if ({res_valid, res_par, res_err, res_sat} !== 4'b1100 || res_len !== 8'd2) begin
      n_bad++;
      $display("FAIL two_beat: got v/p/e/s=%b len=%0d want 1100 len=2",
               {res_valid, res_par, res_err, res_sat}, res_len);
    end
    idle_cycle();
    n_cmp++;
    if (res_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL two_beat_drain: got res_valid=%b want 0", res_valid);
    end
  endtask

  task automatic test_one_beat_err();
    beat(8'h07, 1'b1, 1'b1);
    n_cmp++;
    if ({res_valid, res_par, res_err, res_sat} !== 4'b1010 || res_len !== 8'd1) begin
      n_bad++;
      $display("FAIL one_beat_err: got v/p/e/s=%b len=%0d want 1010 len=1",
               {res_valid, res_par, res_err, res_sat}, res_len);
    end
`ifdef GTECH_PARITY_ERRCNT_EN
    n_cmp++;
    if (err_cnt !== 16'd1) begin
      n_bad++;
      $display("FAIL err_cnt: got %0d want 1", err_cnt);
    end
`endif
    idle_cycle();
  endtask

  task automatic test_backpressure();
    res_ready = 1'b0;
    beat(8'h03, 1'b1, 1'b1);
    n_cmp++;
    if ({res_valid, res_par, res_err} !== 3'b110 || res_len !== 8'd1) begin
      n_bad++;
      $display("FAIL bp_load: got v/p/e=%b len=%0d want 110 len=1",
               {res_valid, res_par, res_err}, res_len);
    end
    // Offer a new last beat while the result is stalled; it must not be taken.
    in_valid = 1'b1; in_data = 8'h07; in_last = 1'b1; in_par = 1'b0;
    idle_cycle();
    idle_cycle();
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_in_ready: got %b want 0", in_ready);
    end
    n_cmp++;
    if ({res_valid, res_par, res_err} !== 3'b110 || res_len !== 8'd1) begin
      n_bad++;
      $display("FAIL bp_hold: got v/p/e=%b len=%0d want 110 len=1",
               {res_valid, res_par, res_err}, res_len);
    end
    res_ready = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_release_ready: got %b want 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n_cmp++;
    if ({res_valid, res_par, res_err} !== 3'b100 || res_len !== 8'd1) begin
      n_bad++;
      $display("FAIL bp_replace: got v/p/e=%b len=%0d want 100 len=1",
               {res_valid, res_par, res_err}, res_len);
    end
    idle_cycle();
  endtask

  task automatic test_saturation();
    res_ready2 = 1'b1;
    for (int i = 0; i < 4; i++) beat2(8'h00, 1'b0, 1'b0);
    beat2(8'h00, 1'b1, 1'b1);
    n_cmp++;
    if ({res_valid2, res_par2, res_err2, res_sat2} !== 4'b1101 || res_len2 !== 2'd3) begin
      n_bad++;
      $display("FAIL sat_5beat: got v/p/e/s=%b len=%0d want 1101 len=3",
               {res_valid2, res_par2, res_err2, res_sat2}, res_len2);
    end
    // Exactly the maximum length: not saturated. Parity 1^0^1 = 0 -> xnor 1.
    beat2(8'h01, 1'b0, 1'b0);
    beat2(8'h00, 1'b0, 1'b0);
    beat2(8'h80, 1'b1, 1'b0);
    n_cmp++;
    if ({res_valid2, res_par2, res_err2, res_sat2} !== 4'b1110 || res_len2 !== 2'd3) begin
      n_bad++;
      $display("FAIL sat_3beat: got v/p/e/s=%b len=%0d want 1110 len=3",
               {res_valid2, res_par2, res_err2, res_sat2}, res_len2);
    end
    idle_cycle();
  endtask

  task automatic test_reset_mid_frame();
    res_ready = 1'b1;
    beat(8'h01, 1'b0, 1'b0);
    beat(8'h03, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (res_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_reset_async: got res_valid=%b want 0", res_valid);
    end
    #2 rst = 1'b0;
    idle_cycle();
    n_cmp++;
    if (res_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_reset_stale: got res_valid=%b in_ready=%b want 0 1", res_valid, in_ready);
    end
    beat(8'hFF, 1'b1, 1'b1);
    n_cmp++;
    if ({res_valid, res_par, res_err, res_sat} !== 4'b1100 || res_len !== 8'd1) begin
      n_bad++;
      $display("FAIL mid_reset_frame: got v/p/e/s=%b len=%0d want 1100 len=1",
               {res_valid, res_par, res_err, res_sat}, res_len);
    end
    idle_cycle();
  endtask

  task automatic test_back_to_back();
    logic [7:0] data_tab [4] = '{8'h01, 8'h03, 8'h07, 8'h00};
    logic       par_tab  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    res_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      beat(data_tab[i], 1'b1, 1'b1);
      n_cmp++;
      if (res_valid !== 1'b1 || in_ready !== 1'b1 || res_par !== par_tab[i] ||
          res_err !== ~par_tab[i] || res_len !== 8'd1) begin
        n_bad++;
        $display("FAIL b2b_%0d: got v=%b rdy=%b p=%b e=%b len=%0d want 1 1 %b %b 1", i,
                 res_valid, in_ready, res_par, res_err, res_len, par_tab[i], ~par_tab[i]);
      end
    end
    idle_cycle();
  endtask

  initial begin
    test_reset();
    test_two_beat();
    test_one_beat_err();
    test_backpressure();
    test_saturation();
    test_reset_mid_frame();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
